seg_scan_decoder: RTL
=====================

// Module: seg_scan_decoder
// PURPOSE
//   Reads back a multiplexed, active-low 7-segment display bus (segment lines + digit selects)
//   and recovers the hex nibble shown on each digit. It is the decode direction of the hex->segment
//   encoder and serves as an on-FPGA loopback/monitor of the display drive.
//   A complete frame (every digit captured once) is presented on a valid/ready output.
// PARAMETERS
//   DIGITS         4   number of multiplexed digits (1..8)
//   STABLE_CYCLES  8   consecutive identical sampled cycles required to capture a digit (>=2)
//   CNT_W (localparam) = $clog2(STABLE_CYCLES+1)
// PORTS
//   clk        in   1         system clock
//   rst        in   1         asynchronous, active-high reset
//   seg_n      in   8         segment lines, active low; bit7 = dp, bits6:0 = g..a
//   dig_n      in   DIGITS    digit selects, active low, one-hot when driving
//   out_valid  out  1         frame available
//   out_ready  in   1         consumer accepts frame
//   out_value  out  4*DIGITS  decoded nibbles; digit i in bits [4i+3:4i]
//   out_err    out  DIGITS    bit i set: digit i pattern not a legal hex glyph
//   out_dp     out  DIGITS    captured decimal points (see CONFIGURATION)
//   overrun    out  1         one-cycle pulse: completed frame dropped
// BEHAVIOUR
//   - Reset: out_valid/out_value/out_err/out_dp/overrun = 0; seen mask, counter, frame buffer = 0;
//     sync flops = all ones (inactive). Reset mid-frame discards partial frame.
//   - seg_n, dig_n pass through 2-flop synchronisers; all logic below uses synced values.
//   - Active-high pattern p = ~seg_n[6:0]. Legal: 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7
//     7F=8 6F=9 77=A 7C=B 39=C 5E=D 79=E 71=F. Any other p (incl. blank 00): nibble 0, err=1.
//   - Stability: counter increments while {seg,dig} equals previous cycle AND ~dig is exactly one-hot;
//     any change, zero selects, or >1 select resets counter to 0 and clears the captured flag.
//   - Capture: when counter reaches STABLE_CYCLES-1 and captured flag clear, write nibble/err(/dp)
//     of the selected digit into frame buffer, set seen[i], set captured flag (one capture per window;
//     counter saturates). Recapture of an already-seen digit overwrites its entry.
//   - Latency: pattern at pins -> capture = 2 + STABLE_CYCLES cycles; out_valid rises the cycle after
//     the capture that makes seen all ones. seen clears in that same cycle.
//   - Handshake: out_* hold stable while out_valid & !out_ready. Transfer on out_valid & out_ready;
//     out_valid drops next cycle unless a frame completes in the transfer cycle (then new data loads,
//     out_valid stays 1). Frame completing while out_valid & !out_ready: discarded, overrun pulses 1 cycle,
//     held output unchanged.
//   - States: SCAN (collecting, out_valid=0), HOLD (out_valid=1, collection continues); HOLD->SCAN
//     on transfer without a simultaneous frame completion.
// CONFIGURATION
//   SEG_DP_CAPTURE_EN defined: out_dp[i] = ~seg_n[7] captured with digit i; dp is part of the
//     stability compare. Not defined: out_dp tied 0, seg_n[7] ignored (not synchronised or compared).
// STRUCTURE
//   - Package seg_pkg: 7-bit glyph constants SEG_GLYPH_0..F; digit-index and nibble widths.
//   - Sub-module seg_pattern_decode: combinational p[6:0] -> {err, nibble[3:0]} using seg_pkg.
//   - Top: synchronisers, one-hot check + index encode, stability counter, frame buffer,
//     seen mask, output register/handshake.
// TESTING
//   1. DIGITS=4: show 1,2,3,4 on digits 0..3, 16 cycles each, out_ready=1 -> out_value=16'h4321,
//      out_err=0, out_valid high exactly 1 cycle.
//   2. Digit 0 pattern 06 held 5 cycles then changed -> no capture; seen stays 0, no out_valid.
//   3. Digit 2 shows 00 (blank), others legal -> out_err=4'b0100, nibble2=0.
//   4. out_ready=0, two full frames -> first frame held unchanged, overrun pulses once at second completion.
//   5. dig_n=4'b1100 (two selects) for 20 cycles -> counter stays 0, no capture.
//   6. rst pulsed after digits 0,1 captured -> all outputs 0; out_valid only after all 4 digits recaptured.
//   +  SEG_DP_CAPTURE_EN: dp lit on digit 3 -> out_dp=4'b1000; undefined build -> out_dp=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder: glyph patterns, widths and FSM states.
package seg_pkg;

  localparam int NIB_W   = 4;
  localparam int GLYPH_W = 7;

  localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
  localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
  localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
  localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
  localparam logic [6:0] SEG_GLYPH_A = 7'h77;
  localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
  localparam logic [6:0] SEG_GLYPH_C = 7'h39;
  localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
  localparam logic [6:0] SEG_GLYPH_E = 7'h79;
  localparam logic [6:0] SEG_GLYPH_F = 7'h71;

  typedef enum logic [0:0] {
    ST_SCAN = 1'b0,
    ST_HOLD = 1'b1
  } scan_state_e;

  // Digit-index width; a single digit still needs one bit to index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational active-high segment pattern -> {err, nibble}; unknown glyphs decode to 0 with err set.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [GLYPH_W-1:0] pattern,
  output logic               err,
  output logic [NIB_W-1:0]   nibble
);

  // Glyph lookup
  always_comb begin
    err    = 1'b0;
    nibble = 4'h0;
    case (pattern)
      SEG_GLYPH_0: nibble = 4'h0;
      SEG_GLYPH_1: nibble = 4'h1;
      SEG_GLYPH_2: nibble = 4'h2;
      SEG_GLYPH_3: nibble = 4'h3;
      SEG_GLYPH_4: nibble = 4'h4;
      SEG_GLYPH_5: nibble = 4'h5;
      SEG_GLYPH_6: nibble = 4'h6;
      SEG_GLYPH_7: nibble = 4'h7;
      SEG_GLYPH_8: nibble = 4'h8;
      SEG_GLYPH_9: nibble = 4'h9;
      SEG_GLYPH_A: nibble = 4'hA;
      SEG_GLYPH_B: nibble = 4'hB;
      SEG_GLYPH_C: nibble = 4'hC;
      SEG_GLYPH_D: nibble = 4'hD;
      SEG_GLYPH_E: nibble = 4'hE;
      SEG_GLYPH_F: nibble = 4'hF;
      default: begin
        err    = 1'b1;
        nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment bus and presents whole decoded frames on valid/ready.
// Optional decimal-point capture is enabled by defining SEG_DP_CAPTURE_EN.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_n,
  input  logic [DIGITS-1:0]       dig_n,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIB_W*DIGITS-1:0] out_value,
  output logic [DIGITS-1:0]       out_err,
  output logic [DIGITS-1:0]       out_dp,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = idx_width(DIGITS);

`ifdef SEG_DP_CAPTURE_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
  logic dp_unused;
  assign dp_unused = seg_n[7];
`endif

  logic [SEG_W-1:0]        seg_meta_r, seg_sync_r, seg_prev_r;
  logic [DIGITS-1:0]       dig_meta_r, dig_sync_r, dig_prev_r;
  logic [DIGITS-1:0]       sel_s;
  logic                    one_hot_s, stable_s, capture_s, frame_done_s;
  logic [IDX_W-1:0]        idx_s;
  logic [CNT_W-1:0]        cnt_r;
  logic                    captured_r;
  logic                    dec_err_s, dp_s;
  logic [NIB_W-1:0]        dec_nib_s;
  logic [NIB_W*DIGITS-1:0] fb_value_r, fb_value_next;
  logic [DIGITS-1:0]       fb_err_r, fb_err_next, fb_dp_r, fb_dp_next;
  logic [DIGITS-1:0]       seen_r, seen_next;
  scan_state_e             state_r, state_next;
  logic                    load_s, overrun_s;

  // Two-flop synchronisers plus one history stage for the stability compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_meta_r <= '1;
      seg_sync_r <= '1;
      seg_prev_r <= '1;
      dig_meta_r <= '1;
      dig_sync_r <= '1;
      dig_prev_r <= '1;
    end else begin
      seg_meta_r <= seg_n[SEG_W-1:0];
      seg_sync_r <= seg_meta_r;
      seg_prev_r <= seg_sync_r;
      dig_meta_r <= dig_n;
      dig_sync_r <= dig_meta_r;
      dig_prev_r <= dig_sync_r;
    end
  end

  assign sel_s     = ~dig_sync_r;
  assign one_hot_s = (sel_s != '0) && ((sel_s & (sel_s - DIGITS'(1))) == '0);
  assign stable_s  = one_hot_s && (seg_sync_r == seg_prev_r) && (dig_sync_r == dig_prev_r);
  assign capture_s = stable_s && (cnt_r == CNT_W'(STABLE_CYCLES - 1)) && !captured_r;

  // One-hot select to digit index (only meaningful when one_hot_s)
  always_comb begin
    idx_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      idx_s = idx_s | (sel_s[i] ? IDX_W'(i) : IDX_W'(0));
    end
  end

  // Stability counter; saturates so each stable window captures exactly once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= '0;
      captured_r <= 1'b0;
    end else if (!stable_s) begin
      cnt_r      <= '0;
      captured_r <= 1'b0;
    end else begin
      if (cnt_r != CNT_W'(STABLE_CYCLES - 1)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (capture_s) begin
        captured_r <= 1'b1;
      end
    end
  end

  seg_pattern_decode u_decode (
    .pattern (~seg_sync_r[6:0]),
    .err     (dec_err_s),
    .nibble  (dec_nib_s)
  );

`ifdef SEG_DP_CAPTURE_EN
  assign dp_s = ~seg_sync_r[7];
`else
  assign dp_s = 1'b0;
`endif

  // Frame buffer with the current capture merged in, so a completing frame loads in one step
  always_comb begin
    fb_value_next = fb_value_r;
    fb_err_next   = fb_err_r;
    fb_dp_next    = fb_dp_r;
    seen_next     = seen_r;
    if (capture_s) begin
      fb_value_next[idx_s*NIB_W +: NIB_W] = dec_nib_s;
      fb_err_next[idx_s]                  = dec_err_s;
      fb_dp_next[idx_s]                   = dp_s;
      seen_next[idx_s]                    = 1'b1;
    end else begin
      seen_next = seen_r;
    end
  end

  assign frame_done_s = capture_s && (&seen_next);

  // Frame buffer and seen mask; seen restarts as soon as a frame completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_value_r <= '0;
      fb_err_r   <= '0;
      fb_dp_r    <= '0;
      seen_r     <= '0;
    end else begin
      fb_value_r <= fb_value_next;
      fb_err_r   <= fb_err_next;
      fb_dp_r    <= fb_dp_next;
      seen_r     <= frame_done_s ? '0 : seen_next;
    end
  end

  // Output handshake state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_SCAN;
    end else begin
      state_r <= state_next;
    end
  end

  // Handshake next state: load on completion unless a held frame is still waiting
  always_comb begin
    state_next = state_r;
    load_s     = 1'b0;
    overrun_s  = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (frame_done_s) begin
          state_next = ST_HOLD;
          load_s     = 1'b1;
        end else begin
          state_next = ST_SCAN;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (frame_done_s) begin
            load_s = 1'b1;
          end else begin
            state_next = ST_SCAN;
          end
        end else begin
          overrun_s = frame_done_s;
        end
      end
      default: begin
        state_next = ST_SCAN;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      out_value <= '0;
      out_err   <= '0;
      out_dp    <= '0;
    end else begin
      out_valid <= (state_next == ST_HOLD);
      overrun   <= overrun_s;
      if (load_s) begin
        out_value <= fb_value_next;
        out_err   <= fb_err_next;
        out_dp    <= fb_dp_next;
      end
    end
  end

endmodule
